// File: rtl/dac_write_arbiter.sv
// Shares the serial comparator-threshold DAC between three word sources: grants one request,
// latches its word and shifts it out MSB-first on SYNC/SCLK/DIN. DAC_ARB_RR_EN selects round-robin.
module dac_write_arbiter #(
  parameter int unsigned SCLK_DIV = 4,
  parameter int unsigned SYNC_GAP = 2,
  parameter int unsigned WORD_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [2:0]          req,
  input  logic [3*WORD_W-1:0] req_data,
  output logic [2:0]          ack,
  output logic                done,
  output logic                busy,
  output logic [1:0]          last_src,
  output logic                dac_sync_n,
  output logic                dac_sclk,
  output logic                dac_din
);
  localparam int unsigned DIV_W = 8;
  localparam int unsigned CNT_W = 5;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(SYNC_GAP - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        ack_q, ack_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [1:0]        last_src_q, last_src_d;
  logic              sync_n_q, sync_n_d;
  logic              sclk_q, sclk_d;
  logic              din_q, din_d;

  logic              gnt_vld_c;
  logic [1:0]        gnt_idx_c;
  logic [WORD_W-1:0] gnt_word_c;

`ifdef DAC_ARB_RR_EN
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] cand0_c, cand1_c, cand2_c;

  function automatic logic [1:0] next_src(input logic [1:0] s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  // Search order starts one past the last winner so a held request cannot starve the rest
  always_comb begin
    cand0_c   = next_src(rr_ptr_q);
    cand1_c   = next_src(cand0_c);
    cand2_c   = next_src(cand1_c);
    gnt_vld_c = |req;
    gnt_idx_c = cand0_c;
    if (req[cand0_c])      gnt_idx_c = cand0_c;
    else if (req[cand1_c]) gnt_idx_c = cand1_c;
    else if (req[cand2_c]) gnt_idx_c = cand2_c;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rr_ptr_q <= 2'd2;
    else      rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority: modulator, then threshold override, then init word
  always_comb begin
    gnt_vld_c = |req;
    gnt_idx_c = 2'd0;
    if (req[0])      gnt_idx_c = 2'd0;
    else if (req[1]) gnt_idx_c = 2'd1;
    else if (req[2]) gnt_idx_c = 2'd2;
  end
`endif

  always_comb begin
    gnt_word_c = req_data[WORD_W-1:0];
    case (gnt_idx_c)
      2'd1:    gnt_word_c = req_data[2*WORD_W-1:WORD_W];
      2'd2:    gnt_word_c = req_data[3*WORD_W-1:2*WORD_W];
      default: gnt_word_c = req_data[WORD_W-1:0];
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    ack_d      = 3'b000;
    done_d     = 1'b0;
    busy_d     = busy_q;
    last_src_d = last_src_q;
    sync_n_d   = sync_n_q;
    sclk_d     = sclk_q;
    din_d      = din_q;
`ifdef DAC_ARB_RR_EN
    rr_ptr_d   = rr_ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld_c) begin
          state_d    = ST_SHIFT;
          ack_d      = 3'b001 << gnt_idx_c;
          shift_d    = gnt_word_c;
          last_src_d = gnt_idx_c;
          busy_d     = 1'b1;
          sync_n_d   = 1'b0;
          sclk_d     = 1'b1;
          din_d      = gnt_word_c[WORD_W-1];
          div_d      = '0;
          cnt_d      = '0;
`ifdef DAC_ARB_RR_EN
          rr_ptr_d   = gnt_idx_c;
`endif
        end
      end
      ST_SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          sclk_d = ~sclk_q;
          // Rising SCLK: present the next bit; the 16th rise closes the frame
          if (!sclk_q) begin
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
            din_d   = shift_q[WORD_W-2];
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == BIT_LAST) begin
              state_d  = ST_GAP;
              sync_n_d = 1'b1;
              done_d   = 1'b1;
              cnt_d    = '0;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        // Gap counts whole SCLK half-periods so the divider stays 8 bits
        if (div_q == DIV_LAST) begin
          div_d = '0;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == GAP_LAST) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = '0;
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      div_q      <= '0;
      cnt_q      <= '0;
      ack_q      <= 3'b000;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      last_src_q <= 2'd0;
      sync_n_q   <= 1'b1;
      sclk_q     <= 1'b1;
      din_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      last_src_q <= last_src_d;
      sync_n_q   <= sync_n_d;
      sclk_q     <= sclk_d;
      din_q      <= din_d;
    end
  end

  assign ack        = ack_q;
  assign done       = done_q;
  assign busy       = busy_q;
  assign last_src   = last_src_q;
  assign dac_sync_n = sync_n_q;
  assign dac_sclk   = sclk_q;
  assign dac_din    = din_q;

endmodule

// File: tb/tb_dac_write_arbiter.sv
// Bench for dac_write_arbiter: a frame-timeline model (grant time + arithmetic) checks every
// output each cycle; directed scenarios add literal timing/data expectations.
module tb_dac_write_arbiter;
  localparam int SCLK_DIV = 4;
  localparam int SYNC_GAP = 2;
  localparam int FRAME    = 32 * SCLK_DIV;
  localparam int BUSY_LEN = FRAME + SYNC_GAP * SCLK_DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [47:0] req_data = 48'd0;
  logic [2:0]  ack;
  logic        done, busy, dac_sync_n, dac_sclk, dac_din;
  logic [1:0]  last_src;

  dac_write_arbiter #(.SCLK_DIV(SCLK_DIV), .SYNC_GAP(SYNC_GAP), .WORD_W(16)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .busy(busy), .last_src(last_src), .dac_sync_n(dac_sync_n), .dac_sclk(dac_sclk),
    .dac_din(dac_din)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Arbitration rule from the requester's point of view
  function automatic int pick(input logic [2:0] r, input int ptr);
`ifdef DAC_ARB_RR_EN
    for (int k = 1; k <= 3; k++) if (r[(ptr + k) % 3]) return (ptr + k) % 3;
`else
    for (int k = 0; k < 3; k++) if (r[k]) return k;
`endif
    return -1;
  endfunction

  // Model state: a frame is described only by its grant cycle, source and word
  int          cyc = 0;
  logic [2:0]  s_req;
  logic [47:0] s_data;
  logic        s_rst;
  bit          m_active = 0, m_busy_prev = 0;
  int          m_g = 0, m_t = 0, m_last = 0, m_ptr = 2, rel = 0;
  logic [15:0] m_word = 16'd0;
  logic [2:0]  e_ack;
  logic        e_busy, e_sync_n, e_sclk, e_done, e_frame;
  logic        dut_busy_prev = 1'b0;
  int          ack_cyc[$], ack_src[$], done_cyc[$], bfall_cyc[$];

  always @(posedge clk) begin
    s_req  = req;
    s_data = req_data;
    s_rst  = rst;
    cyc++;
    if (!s_rst) begin
      m_active = 0; m_last = 0; m_ptr = 2;
    end else if (!m_busy_prev && s_req != 3'b000) begin
      m_g      = pick(s_req, m_ptr);
      m_word   = s_data[m_g*16 +: 16];
      m_t      = cyc;
      m_active = 1;
      m_last   = m_g;
      m_ptr    = m_g;
    end
    #1;
    rel = cyc - m_t;
    if (m_active && rel >= BUSY_LEN) m_active = 0;
    e_frame  = m_active && rel < FRAME;
    e_ack    = (m_active && rel == 0) ? (3'b001 << m_g) : 3'b000;
    e_busy   = m_active;
    e_sync_n = !e_frame;
    e_sclk   = e_frame ? (((rel / SCLK_DIV) % 2) == 0) : 1'b1;
    e_done   = m_active && rel == FRAME;
    check("ack", 32'(ack), 32'(e_ack));
    check("busy", 32'(busy), 32'(e_busy));
    check("done", 32'(done), 32'(e_done));
    check("sync_n", 32'(dac_sync_n), 32'(e_sync_n));
    check("sclk", 32'(dac_sclk), 32'(e_sclk));
    check("last_src", 32'(last_src), 32'(m_last));
    if (e_frame) check("din", 32'(dac_din), 32'(m_word[15 - rel / (2 * SCLK_DIV)]));
    if (!s_rst) check("din_rst", 32'(dac_din), 32'd0);
    m_busy_prev = e_busy;
    if (s_rst) begin
      if (ack != 3'b000) begin
        ack_cyc.push_back(cyc);
        for (int k = 0; k < 3; k++) if (ack[k]) ack_src.push_back(k);
      end
      if (done) done_cyc.push_back(cyc);
      if (dut_busy_prev && !busy) bfall_cyc.push_back(cyc);
    end
    dut_busy_prev = busy;
  end

  // What the DAC itself latches: DIN on each SCLK fall inside a frame
  logic [15:0] cap = 16'd0;
  int          cap_n = 0;
  always @(negedge dac_sync_n) begin cap = 16'd0; cap_n = 0; end
  always @(negedge dac_sclk) if (dac_sync_n == 1'b0) begin cap = {cap[14:0], dac_din}; cap_n++; end

  task automatic wait_ack(input string tag, output int src);
    int n = 0;
    src = -1;
    @(negedge clk);
    while (ack == 3'b000 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_ack_timeout"}, 32'(ack != 3'b000), 32'd1);
    for (int k = 0; k < 3; k++) if (ack[k]) src = k;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    @(negedge clk);
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
  endtask

  int s, n0, nd, src6[4];
  logic [2:0] nr;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_sync_n", 32'(dac_sync_n), 32'd1);
    check("rst_sclk", 32'(dac_sclk), 32'd1);
    check("rst_last_src", 32'(last_src), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single modulator word
    req_data = {16'hA5A5, 16'h3C3C, 16'h07B0};
    req = 3'b001;
    wait_ack("t1", s);
    check("t1_ack", 32'(ack), 32'd1);
    req = 3'b000;
    req_data = {16'($urandom), 32'($urandom)};
    wait_idle("t1");
    check("t1_din_word", 32'(cap), 32'h07B0);
    check("t1_din_bits", 32'(cap_n), 32'd16);
    check("t1_ack_to_done", 32'(done_cyc[$] - ack_cyc[$]), 32'd128);
    check("t1_done_to_idle", 32'(bfall_cyc[$] - done_cyc[$]), 32'd8);

    // 2: all three requesting at once, each drops after its ack
    repeat (3) @(negedge clk);
    n0 = ack_cyc.size();
    req_data = {16'h1111, 16'h2222, 16'h3333};
    req = 3'b111;
    for (int i = 0; i < 3; i++) begin
      wait_ack("t2", s);
      if (s >= 0) req[s] = 1'b0;
    end
    wait_idle("t2");
`ifdef DAC_ARB_RR_EN
    check("t2_order0", 32'(ack_src[n0]), 32'd1);
    check("t2_order1", 32'(ack_src[n0+1]), 32'd2);
    check("t2_order2", 32'(ack_src[n0+2]), 32'd0);
`else
    check("t2_order0", 32'(ack_src[n0]), 32'd0);
    check("t2_order1", 32'(ack_src[n0+1]), 32'd1);
    check("t2_order2", 32'(ack_src[n0+2]), 32'd2);
`endif
    check("t2_spacing1", 32'(ack_cyc[n0+1] - ack_cyc[n0]), 32'd137);
    check("t2_spacing2", 32'(ack_cyc[n0+2] - ack_cyc[n0+1]), 32'd137);

    // 3: threshold request raised mid-frame waits for the gap to end
    req = 3'b001;
    wait_ack("t3a", s);
    req = 3'b000;
    repeat (40) @(negedge clk);
    req = 3'b010;
    wait_ack("t3b", s);
    req = 3'b000;
    check("t3_src", 32'(s), 32'd1);
    check("t3_after_busy", 32'(ack_cyc[$] - bfall_cyc[$]), 32'd1);
    wait_idle("t3");

    // 4: reset mid-frame aborts without done; held request restarts after release
    req_data = {16'hBEEF, 16'h0000, 16'h0000};
    req = 3'b100;
    wait_ack("t4a", s);
    nd = done_cyc.size();
    repeat (60) @(negedge clk);
    rst = 1'b0;
    #1;
    check("t4_sync_n_now", 32'(dac_sync_n), 32'd1);
    check("t4_sclk_now", 32'(dac_sclk), 32'd1);
    check("t4_busy_now", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    wait_ack("t4b", s);
    req = 3'b000;
    check("t4_src", 32'(s), 32'd2);
    check("t4_no_done", 32'(done_cyc.size() - nd), 32'd0);
    wait_idle("t4");
    check("t4_word", 32'(cap), 32'hBEEF);

    // 5: one-cycle init pulse while busy is never served
    req = 3'b001;
    wait_ack("t5", s);
    req = 3'b000;
    n0 = ack_cyc.size();
    repeat (30) @(negedge clk);
    req = 3'b100;
    @(negedge clk);
    req = 3'b000;
    wait_idle("t5");
    repeat (10) @(negedge clk);
    check("t5_no_ack", 32'(ack_cyc.size() - n0), 32'd0);

    // 6: two sources held continuously
    req = 3'b011;
    for (int i = 0; i < 4; i++) begin wait_ack("t6", s); src6[i] = s; end
    req = 3'b000;
    wait_idle("t6");
`ifdef DAC_ARB_RR_EN
    for (int i = 1; i < 4; i++) check("t6_alternate", 32'(src6[i] != src6[i-1]), 32'd1);
    for (int i = 0; i < 4; i++) check("t6_range", 32'(src6[i] < 2), 32'd1);
`else
    for (int i = 0; i < 4; i++) check("t6_fixed", 32'(src6[i]), 32'd0);
`endif

    // Random traffic: requesters honour the drop-after-ack rule, data churns every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      nr = req;
      if (ack != 3'b000) nr = nr & ~ack;
      if ($urandom_range(0, 9) == 0) nr = nr | 3'($urandom_range(1, 7));
      if ($urandom_range(0, 19) == 0) nr = nr & 3'($urandom_range(0, 7));
      req = nr;
      req_data = {16'($urandom), 32'($urandom)};
    end
    req = 3'b000;
    wait_idle("rand");
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
